// File: rtl/jtag_arbiter_pkg.sv
// Shared JTAG sequencer opcodes, arbiter state encodings and the command word layout.
package jtag_arbiter_pkg;

  localparam logic [4:0] FIFO_CMD_NOP     = 5'd0;
  localparam logic [4:0] FIFO_CMD_WR      = 5'd1;
  localparam logic [4:0] FIFO_CMD_STORE   = 5'd2;
  localparam logic [4:0] FIFO_CMD_EXECUTE = 5'd3;
  localparam logic [4:0] FIFO_CMD_FLUSH   = 5'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [7:0] tms;
    logic [7:0] tdi;
    logic [7:0] read;
    logic [2:0] bits;
    logic [4:0] command;
  } seq_cmd_t;

endpackage

// File: rtl/jtag_arbiter_if.sv
// Arbiter <-> JTAG controller link: command stream out, TDO/flush return path in.
interface jtag_arbiter_if;
  logic       out_seq_empty;
  logic [7:0] out_seq_tms;
  logic [7:0] out_seq_tdi;
  logic [7:0] out_seq_read;
  logic [2:0] out_seq_bits;
  logic [4:0] out_seq_command;
  logic       out_seq_re;
  logic       in_seq_full;
  logic       in_seq_we;
  logic [7:0] in_seq_tdo;
  logic       in_seq_flushed;

  modport master (
    output out_seq_empty, out_seq_tms, out_seq_tdi, out_seq_read, out_seq_bits,
           out_seq_command, in_seq_full,
    input  out_seq_re, in_seq_we, in_seq_tdo, in_seq_flushed
  );

  modport slave (
    input  out_seq_empty, out_seq_tms, out_seq_tdi, out_seq_read, out_seq_bits,
           out_seq_command, in_seq_full,
    output out_seq_re, in_seq_we, in_seq_tdo, in_seq_flushed
  );
endinterface

// File: rtl/jtag_arbiter.sv
// Two-requester JTAG command arbiter: whole transactions (up to FLUSH) are granted round-robin,
// an owner idle for TIMEOUT cycles is terminated with a synthetic FLUSH.
module jtag_arbiter
  import jtag_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_empty,
  input  logic [7:0] req0_tms,
  input  logic [7:0] req0_tdi,
  input  logic [7:0] req0_read,
  input  logic [2:0] req0_bits,
  input  logic [4:0] req0_command,
  output logic       req0_re,
  input  logic       req0_full,
  output logic       req0_tdo_we,
  output logic [7:0] req0_tdo,
  output logic       req0_flushed,
  output logic       req0_aborted,
  input  logic       req1_empty,
  input  logic [7:0] req1_tms,
  input  logic [7:0] req1_tdi,
  input  logic [7:0] req1_read,
  input  logic [2:0] req1_bits,
  input  logic [4:0] req1_command,
  output logic       req1_re,
  input  logic       req1_full,
  output logic       req1_tdo_we,
  output logic [7:0] req1_tdo,
  output logic       req1_flushed,
  output logic       req1_aborted,
  jtag_arbiter_if.master seq,
  output logic [1:0] grant
);

  logic [1:0]  state;
  logic        owner;
  logic        last_grant;
  logic        abort_rec;
  logic [15:0] idle_cnt;
  logic [1:0]  drain_cnt;

  seq_cmd_t    cmd0, cmd1, own_cmd;
  logic        own_empty, own_full, pick, busy;
  logic [15:0] idle_nxt;

  assign cmd0 = '{tms: req0_tms, tdi: req0_tdi, read: req0_read, bits: req0_bits, command: req0_command};
  assign cmd1 = '{tms: req1_tms, tdi: req1_tdi, read: req1_read, bits: req1_bits, command: req1_command};

  // On a tie the requester not granted last wins; otherwise whoever is non-empty.
  always_comb begin
    own_cmd   = owner ? cmd1 : cmd0;
    own_empty = owner ? req1_empty : req0_empty;
    own_full  = owner ? req1_full : req0_full;
    pick      = (!req0_empty && !req1_empty) ? ~last_grant : req0_empty;
    idle_nxt  = idle_cnt + 16'd1;
  end

  assign busy  = (state != ST_IDLE);
  assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    seq.out_seq_empty   = 1'b1;
    seq.out_seq_tms     = 8'h00;
    seq.out_seq_tdi     = 8'h00;
    seq.out_seq_read    = 8'h00;
    seq.out_seq_bits    = 3'd0;
    seq.out_seq_command = 5'd0;
    req0_re             = 1'b0;
    req1_re             = 1'b0;
    case (state)
      ST_OWN: begin
        seq.out_seq_empty   = own_empty;
        seq.out_seq_tms     = own_cmd.tms;
        seq.out_seq_tdi     = own_cmd.tdi;
        seq.out_seq_read    = own_cmd.read;
        seq.out_seq_bits    = own_cmd.bits;
        seq.out_seq_command = own_cmd.command;
        req0_re             = !owner && seq.out_seq_re;
        req1_re             = owner && seq.out_seq_re;
      end
      ST_ABORT: begin
        seq.out_seq_empty   = 1'b0;
        seq.out_seq_command = FIFO_CMD_FLUSH;
      end
      default: ;
    endcase
  end

  assign req0_tdo_we     = busy && !owner && seq.in_seq_we;
  assign req1_tdo_we     = busy && owner && seq.in_seq_we;
  assign req0_tdo        = (busy && !owner) ? seq.in_seq_tdo : 8'h00;
  assign req1_tdo        = (busy && owner) ? seq.in_seq_tdo : 8'h00;
  assign seq.in_seq_full = busy && own_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      abort_rec    <= 1'b0;
      idle_cnt     <= 16'd0;
      drain_cnt    <= 2'd0;
      req0_flushed <= 1'b0;
      req1_flushed <= 1'b0;
      req0_aborted <= 1'b0;
      req1_aborted <= 1'b0;
    end else begin
      req0_flushed <= 1'b0;
      req1_flushed <= 1'b0;
      req0_aborted <= 1'b0;
      req1_aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!req0_empty || !req1_empty) begin
            owner      <= pick;
            last_grant <= pick;
            idle_cnt   <= 16'd0;
            abort_rec  <= 1'b0;
            state      <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (seq.out_seq_re) begin
            idle_cnt <= 16'd0;
            if (!own_empty && own_cmd.command == FIFO_CMD_FLUSH) begin
              drain_cnt <= 2'd0;
              state     <= ST_DRAIN;
            end
          end else if (own_empty) begin
            idle_cnt <= idle_nxt;
            if (idle_nxt == TIMEOUT) state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (seq.out_seq_re) begin
            drain_cnt <= 2'd0;
            abort_rec <= 1'b1;
            state     <= ST_DRAIN;
          end
        end
        default: begin
          // drain_cnt saturates at 2: two full cycles have elapsed since the FLUSH pop.
          if (drain_cnt != 2'd2) drain_cnt <= drain_cnt + 2'd1;
          if (seq.in_seq_flushed && drain_cnt == 2'd2) begin
            state        <= ST_IDLE;
            req0_flushed <= !owner && !abort_rec;
            req1_flushed <= owner && !abort_rec;
            req0_aborted <= !owner && abort_rec;
            req1_aborted <= owner && abort_rec;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_arbiter.sv
// Directed bench for jtag_arbiter: requester FIFO models, a JTAG controller model and a command log.
module tb_jtag_arbiter;
  import jtag_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0_empty, req0_re, req0_full, req0_tdo_we, req0_flushed, req0_aborted;
  logic       req1_empty, req1_re, req1_full, req1_tdo_we, req1_flushed, req1_aborted;
  logic [7:0] req0_tdo, req1_tdo;
  logic [1:0] grant;

  seq_cmd_t   mem0 [64];
  seq_cmd_t   mem1 [64];
  logic [6:0] wr0 = 7'd0, wr1 = 7'd0, rd0 = 7'd0, rd1 = 7'd0;
  seq_cmd_t   head0, head1;

  logic       ctrl_en = 1'b0;
  logic       flush_en = 1'b1;
  logic [1:0] flush_cd;

  seq_cmd_t   log_cmd [64];
  logic [1:0] log_grant [64];
  int         nlog = 0;
  int         cnt_fl0 = 0, cnt_fl1 = 0, cnt_ab0 = 0, cnt_ab1 = 0, cnt_we0 = 0;
  logic [7:0] last_tdo0 = 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  jtag_arbiter_if sif ();

  jtag_arbiter #(.TIMEOUT(16'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_empty(req0_empty), .req0_tms(head0.tms), .req0_tdi(head0.tdi),
    .req0_read(head0.read), .req0_bits(head0.bits), .req0_command(head0.command),
    .req0_re(req0_re), .req0_full(req0_full), .req0_tdo_we(req0_tdo_we),
    .req0_tdo(req0_tdo), .req0_flushed(req0_flushed), .req0_aborted(req0_aborted),
    .req1_empty(req1_empty), .req1_tms(head1.tms), .req1_tdi(head1.tdi),
    .req1_read(head1.read), .req1_bits(head1.bits), .req1_command(head1.command),
    .req1_re(req1_re), .req1_full(req1_full), .req1_tdo_we(req1_tdo_we),
    .req1_tdo(req1_tdo), .req1_flushed(req1_flushed), .req1_aborted(req1_aborted),
    .seq(sif.master),
    .grant(grant)
  );

  assign req0_empty = (rd0 == wr0);
  assign req1_empty = (rd1 == wr1);
  assign head0 = mem0[rd0[5:0]];
  assign head1 = mem1[rd1[5:0]];

  always @(posedge clk) begin
    if (req0_re) rd0 <= rd0 + 7'd1;
    if (req1_re) rd1 <= rd1 + 7'd1;
  end

  // Controller model: pops whenever enabled, echoes ~tdi for reads, answers FLUSH three cycles later.
  assign sif.out_seq_re     = ctrl_en && !sif.out_seq_empty;
  assign sif.in_seq_flushed = (flush_cd == 2'd1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sif.in_seq_we  <= 1'b0;
      sif.in_seq_tdo <= 8'h00;
      flush_cd       <= 2'd0;
    end else begin
      sif.in_seq_we  <= sif.out_seq_re && (sif.out_seq_read != 8'h00);
      sif.in_seq_tdo <= sif.out_seq_tdi ^ 8'hFF;
      if (sif.out_seq_re && sif.out_seq_command == FIFO_CMD_FLUSH)
        flush_cd <= flush_en ? 2'd3 : 2'd0;
      else if (flush_cd != 2'd0)
        flush_cd <= flush_cd - 2'd1;
    end
  end

  always @(posedge clk) begin
    if (sif.out_seq_re) begin
      log_cmd[nlog]   <= '{tms: sif.out_seq_tms, tdi: sif.out_seq_tdi, read: sif.out_seq_read,
                           bits: sif.out_seq_bits, command: sif.out_seq_command};
      log_grant[nlog] <= grant;
      nlog            <= nlog + 1;
    end
    if (req0_flushed) cnt_fl0 <= cnt_fl0 + 1;
    if (req1_flushed) cnt_fl1 <= cnt_fl1 + 1;
    if (req0_aborted) cnt_ab0 <= cnt_ab0 + 1;
    if (req1_aborted) cnt_ab1 <= cnt_ab1 + 1;
    if (req0_tdo_we) begin
      cnt_we0   <= cnt_we0 + 1;
      last_tdo0 <= req0_tdo;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic seq_cmd_t mk(input logic [4:0] c, input logic [7:0] tdi,
                                  input logic [7:0] rd, input logic [2:0] bits);
    return '{tms: tdi ^ 8'h3C, tdi: tdi, read: rd, bits: bits, command: c};
  endfunction

  task automatic push0(input seq_cmd_t c);
    mem0[wr0[5:0]] = c;
    wr0 = wr0 + 7'd1;
  endtask

  task automatic push1(input seq_cmd_t c);
    mem1[wr1[5:0]] = c;
    wr1 = wr1 + 7'd1;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (nlog < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_log_reached"}, 32'(nlog >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    repeat (2) @(negedge clk);
    while (grant != 2'b00 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_idle"}, 32'(grant), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b, fl0, fl1, ab0, we0, k;
    logic early;
    logic [7:0] exp_tdi [7];
    logic [4:0] exp_cmd [7];
    logic [1:0] exp_gnt [7];

    req0_full = 1'b0;
    req1_full = 1'b0;

    // Reset state
    @(negedge clk);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_seq_out", {sif.out_seq_empty, sif.out_seq_command, sif.out_seq_tdi, sif.out_seq_tms},
              {1'b1, 5'd0, 8'h00, 8'h00});
    check_val("rst_ctl", {req0_re, req1_re, req0_tdo_we, req0_flushed, req0_aborted, sif.in_seq_full},
              6'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests right after reset: req0 first, then req1, no interleave
    ctrl_en = 1'b1;
    b = nlog; fl0 = cnt_fl0; fl1 = cnt_fl1;
    push0(mk(FIFO_CMD_WR, 8'h11, 8'h00, 3'd2));
    push0(mk(FIFO_CMD_FLUSH, 8'h00, 8'h00, 3'd0));
    push1(mk(FIFO_CMD_WR, 8'h22, 8'h00, 3'd4));
    push1(mk(FIFO_CMD_FLUSH, 8'h00, 8'h00, 3'd0));
    wait_log(b + 4, "rr");
    wait_idle("rr");
    check_val("rr_e0", {log_grant[b],   log_cmd[b].command,   log_cmd[b].tdi},   {2'b01, FIFO_CMD_WR, 8'h11});
    check_val("rr_e1", {log_grant[b+1], log_cmd[b+1].command},                   {2'b01, FIFO_CMD_FLUSH});
    check_val("rr_e2", {log_grant[b+2], log_cmd[b+2].command, log_cmd[b+2].tdi}, {2'b10, FIFO_CMD_WR, 8'h22});
    check_val("rr_e3", {log_grant[b+3], log_cmd[b+3].command},                   {2'b10, FIFO_CMD_FLUSH});
    check_val("rr_flushed", {cnt_fl0 - fl0, cnt_fl1 - fl1}, {32'd1, 32'd1});

    // Single WR with read then FLUSH from req0
    b = nlog; fl0 = cnt_fl0; ab0 = cnt_ab0; we0 = cnt_we0;
    push0(mk(FIFO_CMD_WR, 8'hA5, 8'h01, 3'd0));
    push0(mk(FIFO_CMD_FLUSH, 8'h00, 8'h00, 3'd0));
    wait_idle("wr");
    check_val("wr_count", 32'(nlog - b), 32'd2);
    check_val("wr_e0", {log_grant[b], log_cmd[b].command, log_cmd[b].tdi, log_cmd[b].read},
              {2'b01, FIFO_CMD_WR, 8'hA5, 8'h01});
    check_val("wr_e1", {log_grant[b+1], log_cmd[b+1].command}, {2'b01, FIFO_CMD_FLUSH});
    check_val("wr_tdo_we", 32'(cnt_we0 - we0), 32'd1);
    check_val("wr_tdo", 32'(last_tdo0), 32'h5A);
    check_val("wr_pulses", {cnt_fl0 - fl0, cnt_ab0 - ab0}, {32'd1, 32'd0});

    // req1 arrives while req0 owns a STORE burst
    ctrl_en = 1'b0;
    b = nlog; fl0 = cnt_fl0;
    for (int i = 0; i < 4; i++) push0(mk(FIFO_CMD_STORE, 8'(i + 1), 8'h00, 3'd7));
    push0(mk(FIFO_CMD_FLUSH, 8'h00, 8'h00, 3'd0));
    repeat (3) @(negedge clk);
    check_val("st_grant", 32'(grant), 32'd1);
    push1(mk(FIFO_CMD_WR, 8'h99, 8'h00, 3'd1));
    push1(mk(FIFO_CMD_FLUSH, 8'h00, 8'h00, 3'd0));
    ctrl_en = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (req1_re && cnt_fl0 == fl0) early = 1'b1;
      if (nlog >= b + 7 && grant == 2'b00) break;
    end
    check_val("st_req1_early", 32'(early), 32'd0);
    check_val("st_count", 32'(nlog - b), 32'd7);
    exp_tdi = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h99, 8'h00};
    exp_cmd = '{FIFO_CMD_STORE, FIFO_CMD_STORE, FIFO_CMD_STORE, FIFO_CMD_STORE,
                FIFO_CMD_FLUSH, FIFO_CMD_WR, FIFO_CMD_FLUSH};
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    for (int i = 0; i < 7; i++)
      check_val($sformatf("st_e%0d", i), {log_grant[b+i], log_cmd[b+i].command, log_cmd[b+i].tdi},
                {exp_gnt[i], exp_cmd[i], exp_tdi[i]});
    repeat (2) @(negedge clk);

    // Owner goes empty: synthetic FLUSH after 16 idle cycles, aborted not flushed
    b = nlog; fl0 = cnt_fl0; ab0 = cnt_ab0;
    push0(mk(FIFO_CMD_WR, 8'h77, 8'h00, 3'd3));
    wait_log(b + 1, "to");
    k = 0;
    while (sif.out_seq_empty && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("to_idle_cycles", 32'(k), 32'd16);
    check_val("to_abort_cmd", {grant, sif.out_seq_empty, sif.out_seq_command, sif.out_seq_tdi,
                               sif.out_seq_tms, sif.out_seq_read, sif.out_seq_bits},
              {2'b01, 1'b0, FIFO_CMD_FLUSH, 8'h00, 8'h00, 8'h00, 3'd0});
    wait_idle("to");
    check_val("to_pulses", {cnt_ab0 - ab0, cnt_fl0 - fl0}, {32'd1, 32'd0});
    check_val("to_logged", {log_grant[b+1], log_cmd[b+1].command}, {2'b01, FIFO_CMD_FLUSH});

    // Pass-through and full routing while owned
    ctrl_en = 1'b0;
    req0_full = 1'b1;
    push0(mk(FIFO_CMD_WR, 8'h3E, 8'h81, 3'd5));
    push0(mk(FIFO_CMD_FLUSH, 8'h00, 8'h00, 3'd0));
    repeat (2) @(negedge clk);
    check_val("pt_grant", 32'(grant), 32'd1);
    check_val("pt_fields", {sif.out_seq_empty, sif.out_seq_tms, sif.out_seq_tdi, sif.out_seq_read,
                            sif.out_seq_bits, sif.out_seq_command},
              {1'b0, 8'h02, 8'h3E, 8'h81, 3'd5, FIFO_CMD_WR});
    check_val("pt_full_owner", 32'(sif.in_seq_full), 32'd1);
    req0_full = 1'b0;
    req1_full = 1'b1;
    #1;
    check_val("pt_full_nonowner", 32'(sif.in_seq_full), 32'd0);
    ctrl_en = 1'b1;
    #1;
    check_val("pt_re", {req0_re, req1_re}, 2'b10);
    wait_idle("pt");
    req0_full = 1'b1;
    #1;
    check_val("pt_full_idle", 32'(sif.in_seq_full), 32'd0);
    req0_full = 1'b0;
    req1_full = 1'b0;

    // Reset while draining: immediate release, no pulses, normal grant afterwards
    flush_en = 1'b0;
    b = nlog; fl0 = cnt_fl0; ab0 = cnt_ab0;
    push0(mk(FIFO_CMD_WR, 8'h42, 8'h00, 3'd0));
    push0(mk(FIFO_CMD_FLUSH, 8'h00, 8'h00, 3'd0));
    wait_log(b + 2, "rd");
    repeat (2) @(negedge clk);
    check_val("rd_drain_grant", {grant, sif.out_seq_empty, req0_re}, {2'b01, 1'b1, 1'b0});
    #1 rst_n = 1'b0;
    #1;
    check_val("rd_async_grant", 32'(grant), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rd_no_pulse", {cnt_fl0 - fl0, cnt_ab0 - ab0}, {32'd0, 32'd0});
    flush_en = 1'b1;
    b = nlog; fl0 = cnt_fl0;
    push0(mk(FIFO_CMD_WR, 8'h43, 8'h00, 3'd0));
    push0(mk(FIFO_CMD_FLUSH, 8'h00, 8'h00, 3'd0));
    wait_log(b + 2, "rd2");
    wait_idle("rd2");
    check_val("rd2_e0", {log_grant[b], log_cmd[b].command, log_cmd[b].tdi}, {2'b01, FIFO_CMD_WR, 8'h43});
    check_val("rd2_flushed", 32'(cnt_fl0 - fl0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
